// File: rtl/mips_fetch.sv
// mips_fetch: PC and instruction-memory fetch with a small queue feeding the decoder.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int QDEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  input  logic        except,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0] qinst_q [QDEPTH];
  logic [31:0] qpc_q [QDEPTH];
  logic xfer, pop, exc, flush, push;
  assign imem_req   = ~reset & (state_q == RUN) & (count_q < CW'(QDEPTH)) & ~redirect;
  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0) & (state_q == RUN);
  assign halted     = (state_q == HALTED);
  assign inst       = qinst_q[rd_q];
  assign inst_pc    = qpc_q[rd_q];
  assign opcode     = inst[31:26];
  assign funct      = inst[5:0];
  assign rs         = inst[25:21];
  assign rt         = inst[20:16];
  assign rd         = inst[15:11];
  assign imm16      = inst[15:0];
  always_comb begin
    xfer    = imem_req & imem_ack;
    pop     = inst_valid & inst_ready;
    exc     = pop & except & ~redirect;
    flush   = redirect | exc;
    push    = xfer & ~exc;
    state_d = redirect ? RUN : exc ? HALTED : state_q;
    pc_d    = redirect ? (redirect_pc & ~32'h3) : push ? pc_q + 32'd4 : pc_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d    = flush ? '0 : wr_q + PW'(push);
    rd_d    = flush ? '0 : rd_q + PW'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  // Queue storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      qinst_q[wr_q] <= imem_data;
      qpc_q[wr_q]   <= pc_q;
    end
  end
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed checks of fetch sequencing, queue backpressure, halt, redirect and reset.
module tb_mips_fetch;
  logic clock = 0, reset, imem_ack, inst_ready, except, redirect;
  logic [31:0] imem_addr, imem_data, inst, inst_pc, redirect_pc, data_ovr;
  logic imem_req, inst_valid, halted, use_ovr;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  int checks = 0, errors = 0, xf;
  always #5 clock = ~clock;
  // Memory returns the bitwise inverse of the address unless overridden.
  assign imem_data = use_ovr ? data_ovr : ~imem_addr;
  mips_fetch dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .except(except), .redirect(redirect),
    .redirect_pc(redirect_pc), .halted(halted)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1; imem_ack = 1; inst_ready = 1; except = 0; redirect = 0;
    redirect_pc = 0; use_ovr = 0; data_ovr = 0;
    #1 chk("rst_req", imem_req, 0);
    cyc; reset = 0; #1;
    chk("c1_req", imem_req, 1); chk("c1_addr", imem_addr, 32'h00400000);
    chk("c1_valid", inst_valid, 0); chk("c1_halted", halted, 0);
    cyc; #1;
    chk("c2_addr", imem_addr, 32'h00400004); chk("c2_valid", inst_valid, 1);
    chk("c2_pc", inst_pc, 32'h00400000); chk("c2_inst", inst, 32'hFFBFFFFF);
    cyc; #1;
    chk("c3_addr", imem_addr, 32'h00400008); chk("c3_valid", inst_valid, 1);
    chk("c3_pc", inst_pc, 32'h00400004);
    // backpressure from an empty queue
    cyc; reset = 1; inst_ready = 0; #1;
    chk("rst2_req", imem_req, 0);
    xf = 0;
    for (int i = 0; i < 5; i++) begin
      cyc; reset = 0; #1;
      xf += int'(imem_req & imem_ack);
    end
    chk("bp_xfers", xf, 2); chk("bp_req", imem_req, 0);
    chk("bp_pc", inst_pc, 32'h00400000);
    inst_ready = 1; #1;
    chk("bp_nolook", imem_req, 0);
    cyc; #1;
    chk("pop1_pc", inst_pc, 32'h00400004); chk("pop1_addr", imem_addr, 32'h00400008);
    chk("pop1_req", imem_req, 1);
    cyc; #1;
    chk("pop2_pc", inst_pc, 32'h00400008); chk("pop2_addr", imem_addr, 32'h0040000C);
    // field split of add $9,$10,$11
    use_ovr = 1; data_ovr = 32'h014B4820;
    cyc; use_ovr = 0; #1;
    chk("f_inst", inst, 32'h014B4820); chk("f_op", opcode, 0); chk("f_funct", funct, 6'h20);
    chk("f_rs", rs, 10); chk("f_rt", rt, 11); chk("f_rd", rd, 9);
    chk("f_imm", imm16, 16'h4820); chk("f_pc", inst_pc, 32'h0040000C);
    // exception with a simultaneous transfer
    chk("ex_addr0", imem_addr, 32'h00400010);
    except = 1;
    cyc; except = 0; #1;
    chk("ex_halted", halted, 1); chk("ex_valid", inst_valid, 0);
    chk("ex_req", imem_req, 0); chk("ex_pc", imem_addr, 32'h00400010);
    cyc; #1;
    chk("ex_hold", halted, 1); chk("ex_ignack", inst_valid, 0);
    redirect = 1; redirect_pc = 32'h00400103; #1;
    chk("rd_req", imem_req, 0);
    cyc; redirect = 0; #1;
    chk("rd_halted", halted, 0); chk("rd_addr", imem_addr, 32'h00400100);
    chk("rd_req1", imem_req, 1);
    cyc; #1;
    chk("rd_valid", inst_valid, 1); chk("rd_pc", inst_pc, 32'h00400100);
    // redirect beats except during a multi-cycle wait
    imem_ack = 0; inst_ready = 0;
    cyc; #1;
    chk("w_addr", imem_addr, 32'h00400104); chk("w_req", imem_req, 1);
    cyc; redirect = 1; except = 1; inst_ready = 1; imem_ack = 1;
    redirect_pc = 32'h00500000; #1;
    chk("re_req", imem_req, 0);
    cyc; redirect = 0; except = 0; imem_ack = 0; #1;
    chk("re_halted", halted, 0); chk("re_valid", inst_valid, 0);
    chk("re_addr", imem_addr, 32'h00500000);
    imem_ack = 1;
    cyc; #1;
    chk("re_pc", inst_pc, 32'h00500000); chk("re_inst", inst, 32'hFFAFFFFF);
    // reset with a full queue, then reset mid-wait
    inst_ready = 0;
    cyc; #1;
    chk("full_req", imem_req, 0);
    reset = 1; #1;
    chk("rst3_req", imem_req, 0);
    cyc; reset = 0; imem_ack = 0; #1;
    chk("rst3_valid", inst_valid, 0); chk("rst3_addr", imem_addr, 32'h00400000);
    chk("rst3_wait", imem_req, 1);
    reset = 1; imem_ack = 1;
    cyc; reset = 0; imem_ack = 0; #1;
    chk("rst4_valid", inst_valid, 0); chk("rst4_addr", imem_addr, 32'h00400000);
    // PC wrap-around
    inst_ready = 1; imem_ack = 1; redirect = 1; redirect_pc = 32'hFFFFFFFF;
    cyc; redirect = 0; #1;
    chk("wr_addr", imem_addr, 32'hFFFFFFFC);
    cyc; #1;
    chk("wr_wrap", imem_addr, 32'h00000000); chk("wr_pc", inst_pc, 32'hFFFFFFFC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
